reel_bank: RTL
==============

Name: reel_bank

Overview:
- Consumer side of the reel-stop interface: receives per-reel stop requests from the stop-timing generator, spins four reels, decelerates each one on request and locks it on a final symbol.
- Presents the locked symbols to the payout/display logic with a valid/ack handshake.
- Sits between the stop generator (upstream) and the scoring and seven-segment display logic (downstream).

Parameters:
- NUM_REELS, 4, number of reels; stop and locked vectors are this wide.
- SYM_W, 3, symbol index width; symbols run 0 to 2**SYM_W-1.
- STEP_TICKS, 50000, clk cycles per symbol step while the reel is running; must be at least 2.
- DECEL_STEPS, 3, number of slowed steps after a stop request before the reel locks.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- spin_start  in  1  single-cycle pulse that begins a spin.
- stop  in  NUM_REELS  per-reel stop request levels from the stop generator; these are sticky and may already be high.
- result_ack  in  1  downstream consumed the result.
- busy  out  1  high from spin acceptance until result_ack.
- reel_sym  out  NUM_REELS*SYM_W  current symbol of each reel; reel i occupies [i*SYM_W +: SYM_W].
- reel_locked  out  NUM_REELS  per-reel locked flag.
- result_valid  out  1  all reels locked, result stable.
- jackpot  out  1  all reel_sym equal; meaningful only while result_valid is high, otherwise 0.

Behaviour:
- Reset (asynchronous): top FSM=IDLE, every reel FSM=STOPPED, reel_sym=0, reel_locked=0, busy=0, result_valid=0, jackpot=0, LFSR=16'hACE1, stop_prev=0.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Free-running every clk, never all-zero.
- Top FSM states: IDLE, SPIN, RESULT.
  - IDLE, spin_start=1 -> SPIN next cycle.
    - Every reel: reel_sym[i] = LFSR[(i*SYM_W)%16 +: SYM_W] sampled that cycle, tick counter=0, reel FSM=RUN, reel_locked=0.
    - busy=1.
  - SPIN, all reels LOCKED -> RESULT.
    - result_valid=1 and jackpot registered the cycle after the last lock.
  - RESULT, result_ack=1 -> IDLE next cycle.
    - result_valid=0, jackpot=0, busy=0.
    - reel_sym and reel_locked hold for the display.
  - spin_start is ignored in SPIN and RESULT. A spin_start in the same cycle as result_ack is also ignored; it must be re-pulsed in IDLE.
  - result_ack outside RESULT is ignored.
- Stop detection:
  - stop_rise[i] = stop[i] & ~stop_prev[i]; stop_prev is registered every cycle.
  - In RUN, a stop level that was already high when the spin started never triggers. Only a rising edge during RUN triggers.
  - A rising edge while the reel is not in RUN is discarded.
  - A rising edge in the same cycle the reel enters RUN is discarded.
- Per-reel FSM states: STOPPED, RUN, DECEL, LOCKED.
  - RUN:
    - The tick counter counts 0..STEP_TICKS-1.
    - At terminal count, reel_sym increments modulo 2**SYM_W (natural wrap from 7 to 0) and the counter clears.
    - stop_rise -> DECEL, with step index k=0 and counter=0.
  - DECEL:
    - The step period is STEP_TICKS<<(k+1).
    - At terminal count, reel_sym increments and k increments.
    - After DECEL_STEPS increments -> LOCKED, reel_locked[i]=1 in that same cycle.
  - LOCKED: holds until the next accepted spin_start.
  - Counter width = clog2(STEP_TICKS<<DECEL_STEPS).
  - The step in which stop_rise arrives does not complete; the counter restarts.
- Simultaneous stop rises on several reels are handled independently.
- Reels lock in arbitrary order. The result is only valid when all reels are locked.
- The block has no timeout: a reel that never receives a stop rise spins forever. Upstream guarantees delivery of the stop rises.
- Reset asserted mid-spin returns every register to its reset value immediately, with no partial result.

Decomposition:
- Shared slot package holds:
  - reel state encoding (STOPPED/RUN/DECEL/LOCKED);
  - top state encoding;
  - LFSR seed 16'hACE1 and tap constants;
  - default NUM_REELS and SYM_W, shared with the stop generator and display decoder.
- One sub-module, reel_unit, is natural: it contains one reel FSM, the tick counter, the symbol register and stop-edge detection. It is instantiated NUM_REELS times by a generate loop.
- The top level keeps the LFSR, the top FSM, the jackpot compare and the handshake.

Test Plan:
- Bench parameters: STEP_TICKS=4, DECEL_STEPS=2.
- Reset then idle 20 cycles -> reel_sym=0, reel_locked=0, busy=0, result_valid=0; spin_start pulse -> busy=1 next cycle, each reel_sym equal to the matching LFSR slice at the pulse cycle.
- Spin, no stop for 40 cycles -> each reel_sym advances by exactly 1 every 4 cycles and wraps from 7 to 0.
- Stop rises on reels 0..3 at cycles 10,14,18,22 after the spin -> each reel locks 8+16=24 cycles after its rise with exactly 2 extra increments; result_valid=1 one cycle after reel 3 locks; hold ack low 10 cycles -> outputs stable; ack -> result_valid=0 and busy=0 next cycle, reel_sym unchanged.
- stop=4'b1111 held high before and through spin_start -> no reel decelerates; drop stop, then raise it -> all four lock 24 cycles later, in the same cycle.
- Force identical start slices (LFSR preloaded via the bench) and identical stop timing -> jackpot=1 together with result_valid; alter one reel's stop time -> jackpot=0.
- rst_n low mid-DECEL -> all outputs at reset values immediately (asynchronously); spin_start during RESULT and spin_start coincident with ack -> ignored, busy stays as defined.

Source files
------------

// File: rtl/reel_bank_pkg.sv
// Shared slot-machine definitions.
// Holds the reel and top-level state encodings, the LFSR seed and taps, and
// the default reel geometry shared with the stop generator and the display
// decoder. The helper lfsr_next() gives the next state of the 16-bit
// Fibonacci LFSR.
package reel_bank_pkg;

    localparam int DEF_NUM_REELS = 4;
    localparam int DEF_SYM_W     = 3;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        REEL_STOPPED = 2'd0,
        REEL_RUN     = 2'd1,
        REEL_DECEL   = 2'd2,
        REEL_LOCKED  = 2'd3
    } reel_state_e;

    typedef enum logic [1:0] {
        TOP_IDLE   = 2'd0,
        TOP_SPIN   = 2'd1,
        TOP_RESULT = 2'd2
    } top_state_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/reel_bank_reel_unit.sv
// One reel: state machine, step tick counter, symbol register and stop edge
// detection.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load_i       accepted spin: load seed_i, clear counter, enter RUN
//   stop_i       sticky stop request level for this reel
//   seed_i       starting symbol sampled on load_i
//   sym_o        current symbol
//   locked_o     reel has locked on its final symbol
//   state_o      reel state, for the top level and for observation
module reel_unit
    import reel_bank_pkg::*;
#(
    parameter int SYM_W       = DEF_SYM_W,
    parameter int STEP_TICKS  = 50000,
    parameter int DECEL_STEPS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             stop_i,
    input  logic [SYM_W-1:0] seed_i,
    output logic [SYM_W-1:0] sym_o,
    output logic             locked_o,
    output reel_state_e      state_o
);

    localparam int CW = $clog2(STEP_TICKS << DECEL_STEPS);
    localparam int KW = (DECEL_STEPS > 1) ? $clog2(DECEL_STEPS) : 1;

    reel_state_e      state_q;
    logic [SYM_W-1:0] sym_q;
    logic             locked_q;
    logic [CW-1:0]    cnt_q;
    logic [KW-1:0]    k_q;
    logic             stop_prev_q;

    logic stop_rise;
    logic run_term;
    logic decel_term;
    logic last_step;

    assign stop_rise  = stop_i & ~stop_prev_q;
    assign run_term   = (32'(cnt_q) == 32'(STEP_TICKS - 1));
    // Deceleration step k lasts STEP_TICKS << (k+1) cycles.
    assign decel_term = (32'(cnt_q) == ((32'(STEP_TICKS) << (32'(k_q) + 32'd1)) - 32'd1));
    assign last_step  = (32'(k_q) == 32'(DECEL_STEPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= REEL_STOPPED;
            sym_q       <= '0;
            locked_q    <= 1'b0;
            cnt_q       <= '0;
            k_q         <= '0;
            stop_prev_q <= 1'b0;
        end else begin
            stop_prev_q <= stop_i;
            if (load_i) begin
                // A rise coinciding with the load is dropped: the reel is not yet in RUN.
                state_q  <= REEL_RUN;
                sym_q    <= seed_i;
                locked_q <= 1'b0;
                cnt_q    <= '0;
                k_q      <= '0;
            end else begin
                case (state_q)
                    REEL_RUN: begin
                        if (stop_rise) begin
                            // The step in progress is abandoned; deceleration starts fresh.
                            state_q <= REEL_DECEL;
                            cnt_q   <= '0;
                            k_q     <= '0;
                        end else if (run_term) begin
                            sym_q <= sym_q + 1'b1;
                            cnt_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    REEL_DECEL: begin
                        if (decel_term) begin
                            sym_q <= sym_q + 1'b1;
                            cnt_q <= '0;
                            if (last_step) begin
                                state_q  <= REEL_LOCKED;
                                locked_q <= 1'b1;
                            end else begin
                                k_q <= k_q + 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sym_o    = sym_q;
    assign locked_o = locked_q;
    assign state_o  = state_q;

endmodule

// File: rtl/reel_bank.sv
// Reel bank: spins NUM_REELS reels from random start symbols, stops each on
// a rising edge of its stop request and presents the locked result.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   spin_start    single-cycle pulse, accepted only in IDLE
//   stop          per-reel sticky stop request levels
//   result_ack    downstream consumed the result
//   busy          high from spin acceptance until result_ack
//   reel_sym      reel i symbol in [i*SYM_W +: SYM_W]
//   reel_locked   per-reel locked flags
//   result_valid  all reels locked, result stable
//   jackpot       all symbols equal, qualified by result_valid
// Handshake: result_valid rises the cycle after the last reel locks and
// stays high with reel_sym/jackpot stable until a cycle where result_ack is
// high; the following cycle result_valid, jackpot and busy are low.
// result_ack is ignored while result_valid is low.
module reel_bank
    import reel_bank_pkg::*;
#(
    parameter int NUM_REELS   = DEF_NUM_REELS,
    parameter int SYM_W       = DEF_SYM_W,
    parameter int STEP_TICKS  = 50000,
    parameter int DECEL_STEPS = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       spin_start,
    input  logic [NUM_REELS-1:0]       stop,
    input  logic                       result_ack,
    output logic                       busy,
    output logic [NUM_REELS*SYM_W-1:0] reel_sym,
    output logic [NUM_REELS-1:0]       reel_locked,
    output logic                       result_valid,
    output logic                       jackpot
);

    top_state_e  state_q;
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        busy_q;
    logic        valid_q;
    logic        jackpot_q;

    logic        load;
    logic        all_locked;
    logic        all_equal;
    reel_state_e reel_state [NUM_REELS];

    assign lfsr_d = lfsr_next(lfsr_q);
    assign load   = (state_q == TOP_IDLE) && spin_start;

    for (genvar g = 0; g < NUM_REELS; g++) begin : g_reel
        reel_unit #(
            .SYM_W       (SYM_W),
            .STEP_TICKS  (STEP_TICKS),
            .DECEL_STEPS (DECEL_STEPS)
        ) u_reel (
            .clk      (clk),
            .rst_n    (rst_n),
            .load_i   (load),
            .stop_i   (stop[g]),
            .seed_i   (lfsr_q[(g*SYM_W)%16 +: SYM_W]),
            .sym_o    (reel_sym[g*SYM_W +: SYM_W]),
            .locked_o (reel_locked[g]),
            .state_o  (reel_state[g])
        );
    end

    always_comb begin
        all_locked = 1'b1;
        all_equal  = 1'b1;
        for (int i = 0; i < NUM_REELS; i++) begin
            if (reel_state[i] != REEL_LOCKED) all_locked = 1'b0;
            if (reel_sym[i*SYM_W +: SYM_W] != reel_sym[SYM_W-1:0]) all_equal = 1'b0;
        end
    end

    // Free-running; starting from a non-zero seed it never reaches zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= TOP_IDLE;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            jackpot_q <= 1'b0;
        end else begin
            case (state_q)
                TOP_IDLE: begin
                    if (spin_start) begin
                        state_q <= TOP_SPIN;
                        busy_q  <= 1'b1;
                    end
                end
                TOP_SPIN: begin
                    if (all_locked) begin
                        state_q   <= TOP_RESULT;
                        valid_q   <= 1'b1;
                        jackpot_q <= all_equal;
                    end
                end
                TOP_RESULT: begin
                    // A spin_start alongside the ack is not carried into IDLE.
                    if (result_ack) begin
                        state_q   <= TOP_IDLE;
                        busy_q    <= 1'b0;
                        valid_q   <= 1'b0;
                        jackpot_q <= 1'b0;
                    end
                end
                default: state_q <= TOP_IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign jackpot      = jackpot_q;

endmodule
